lsu_core: RTL and testbench
===========================

LSU_CORE -- requirements
Module: lsu_core

Interface
REQ-001 Parameter MEM_WORDS, default 21, number of 32-bit words in the downstream data memory; word index >= MEM_WORDS is out of range.
REQ-002 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 REQ  input  1  access request, sampled only in IDLE.
REQ-005 WE  input  1  1 = store, 0 = load.
REQ-006 FUNCT3  input  3  RV32I width/sign code.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
REQ-007 ADDR  input  32  byte address.
REQ-008 WDATA  input  32  store data, right-aligned.
REQ-009 RDATA  output  32  formatted load result; valid only while DONE=1.
REQ-010 DONE  output  1  one-cycle completion pulse.
REQ-011 BUSY  output  1  high from the cycle after acceptance through the DONE cycle.
REQ-012 ERR  output  1  qualifies DONE; the access faulted.
REQ-013 MEM_EN  output  1  memory enable.
REQ-014 MEM_RW  output  1  memory direction: 1 = write, 0 = read.
REQ-015 MEM_ADDR  output  32  word-aligned byte address (bits [1:0] = 00).
REQ-016 MEM_DIN  output  32  memory write data.
REQ-017 MEM_DOUT  input  32  memory read data; combinational read, same cycle as MEM_EN=1/MEM_RW=0.

Function
REQ-018 A request SHALL be accepted when REQ=1 in IDLE; WE, FUNCT3, ADDR and WDATA SHALL be latched on that edge.
REQ-019 REQ SHALL be ignored while BUSY=1; there is no queuing.
REQ-020 FSM states SHALL be IDLE, RD, WR and RESP; RESP SHALL always return to IDLE.
REQ-021 Load path SHALL be IDLE->RD->RESP.
  - RD: MEM_EN=1, MEM_RW=0; MEM_DOUT captured at the end of RD.
  - DONE is asserted 2 cycles after acceptance.
REQ-022 SW path SHALL be IDLE->WR->RESP.
  - WR: MEM_EN=1, MEM_RW=1, MEM_DIN=WDATA.
REQ-023 SB/SH paths SHALL be IDLE->RD->WR->RESP (read-modify-write).
  - WR writes the captured word with only the addressed byte or halfword lanes replaced.
  - DONE is asserted 3 cycles after acceptance.
REQ-024 Byte lane SHALL be ADDR[1:0]; halfword lane SHALL be ADDR[1]; little-endian lane order.
REQ-025 LB/LH SHALL sign-extend to 32 bits; LBU/LHU SHALL zero-extend; LW SHALL pass the word unchanged.
REQ-026 MEM_EN SHALL be 0 in IDLE and RESP; MEM_ADDR SHALL be {ADDR_latched[31:2],2'b00}.
REQ-027 In RESP: DONE=1; RDATA holds the formatted load data for non-faulting loads and 0 for stores and faulted accesses.
REQ-028 An illegal FUNCT3 or an out-of-range word index SHALL fault.
  - The FSM goes IDLE->RESP with ERR=1 and RDATA=0.
  - No memory cycle is issued.
REQ-029 ERR SHALL be 0 whenever DONE=0.

Reset
REQ-030 RST=1 SHALL force IDLE on the next edge, from any state.
REQ-031 While RST=1, all outputs SHALL be 0 (RDATA, DONE, BUSY, ERR, MEM_EN, MEM_RW, MEM_ADDR, MEM_DIN).
REQ-032 MEM_EN SHALL be gated by !RST combinationally, so a reset during WR suppresses that write.
REQ-033 A REQ coincident with RST=1 SHALL be dropped.

Configuration
REQ-034 Macro LSU_MISALIGN_TRAP_EN SHALL select misalignment handling.
  - Defined: LH/LHU/SH with ADDR[0]=1, or LW/SW with ADDR[1:0]!=00, fault per REQ-028.
  - Undefined: those accesses do not fault.
  - Undefined, halfword: lane = ADDR[1], ADDR[0] ignored.
  - Undefined, word: ADDR[1:0] treated as 00.

Structure
REQ-035 Shared package lsu_pkg SHALL hold:
  - FUNCT3 constants.
  - FSM state typedef/encoding.
  - MEM_WORDS default.
REQ-036 Combinational sub-module lsu_align SHALL perform load extract/extend and store lane merge; the FSM and latches stay in lsu_core.

Verification
REQ-037 Preload word 1 = 0x8899AABB; LB at ADDR 0x5 -> DONE at cycle +2, RDATA=0xFFFFFFAA, ERR=0.
REQ-038 Word 2 = 0x11223344; SB WDATA=0x000000EE at ADDR 0xA -> cycles: RD, WR with MEM_DIN=0x11EE3344; word 2 reads back 0x11EE3344; DONE at +3.
REQ-039 SW 0xCAFEF00D at ADDR 0x0 -> single WR cycle, DONE at +2; LW at 0x0 returns 0xCAFEF00D.
REQ-040 LW at ADDR 0x54 (word 21) -> DONE at +1, ERR=1, RDATA=0, MEM_EN never asserted.
REQ-041 LH at ADDR 0x3.
  - Macro defined: ERR=1.
  - Macro undefined with word 0 = 0x7FFF0001: RDATA=0x00007FFF.
REQ-042 SH accepted, RST=1 in the WR cycle -> no memory write, next state IDLE, DONE never pulses, and REQ during BUSY is ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM
// state encoding and the default data-memory depth.
package lsu_pkg;

   // Default number of 32-bit words behind the LSU
   localparam int LSU_MEM_WORDS = 21;

   // RV32I FUNCT3 width/sign codes (stores reuse the low three)
   localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
   localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
   localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
   localparam logic [2:0] F3_BU = 3'b100;  // LBU
   localparam logic [2:0] F3_HU = 3'b101;  // LHU

   // IDLE is encoded as zero so a gated-off state output reads as IDLE
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

   // True when the width code is a legal load (we=0) or store (we=1)
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      if (we) begin
         ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      end else begin
         ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
              (f3 == F3_BU) || (f3 == F3_HU);
      end
      return ok;
   endfunction

   // True when a legal access is not naturally aligned for its width
   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic bad;
      bad = 1'b0;
      if (f3[1:0] == 2'b01) begin
         bad = off[0];
      end else if (f3[1:0] == 2'b10) begin
         bad = (off != 2'b00);
      end
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: extracts and extends load data
// from a memory word, and merges store data into a memory word.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] word_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] store_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte lane (little-endian) and halfword lane
   always_comb begin
      byte_sel = word_i[7:0];
      case (off_i)
         2'd0:    byte_sel = word_i[7:0];
         2'd1:    byte_sel = word_i[15:8];
         2'd2:    byte_sel = word_i[23:16];
         default: byte_sel = word_i[31:24];
      endcase
      half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
   end

   // Sign- or zero-extend the selected lane into a load result
   always_comb begin
      load_o = 32'h0;
      case (funct3_i)
         F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
         F3_W:    load_o = word_i;
         F3_BU:   load_o = {24'h0, byte_sel};
         F3_HU:   load_o = {16'h0, half_sel};
         default: load_o = 32'h0;
      endcase
   end

   // Replace only the addressed lanes of the word with right-aligned store data
   always_comb begin
      store_o = word_i;
      case (funct3_i)
         F3_B: begin
            case (off_i)
               2'd0:    store_o[7:0]   = wdata_i[7:0];
               2'd1:    store_o[15:8]  = wdata_i[7:0];
               2'd2:    store_o[23:16] = wdata_i[7:0];
               default: store_o[31:24] = wdata_i[7:0];
            endcase
         end
         F3_H: begin
            if (off_i[1]) begin
               store_o[31:16] = wdata_i[15:0];
            end else begin
               store_o[15:0] = wdata_i[15:0];
            end
         end
         F3_W:    store_o = wdata_i;
         default: store_o = word_i;
      endcase
   end

endmodule

// File: rtl/lsu_core.sv
// Load/store unit core: accepts one access at a time, runs it against a
// combinational-read word memory, and returns a one-cycle DONE/ERR/RDATA.
// Sub-word stores are done as read-modify-write.
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned halfword
// and word accesses; when undefined the low address bits are ignored for
// those widths.
//
// Handshake: a request is taken on the edge where REQ=1 and the unit is
// idle (BUSY=0, RST=0); BUSY stays high until and including the single
// DONE cycle, and REQ is ignored for that whole time.
module lsu_core
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = LSU_MEM_WORDS
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ,
   input  logic        WE,
   input  logic [2:0]  FUNCT3,
   input  logic [31:0] ADDR,
   input  logic [31:0] WDATA,
   output logic [31:0] RDATA,
   output logic        DONE,
   output logic        BUSY,
   output logic        ERR,
   output logic        MEM_EN,
   output logic        MEM_RW,
   output logic [31:0] MEM_ADDR,
   output logic [31:0] MEM_DIN,
   input  logic [31:0] MEM_DOUT,
   output lsu_state_e  DBG_STATE
);

   localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

   lsu_state_e  state_q, state_d;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        err_q;
   logic [31:0] word_q;

   logic        accept;
   logic        out_of_range;
   logic        misalign;
   logic        fault_d;
   logic [31:0] load_word;
   logic [31:0] store_word;

   assign accept = (state_q == ST_IDLE) && REQ;

   // Decide at acceptance whether the incoming access must fault
   always_comb begin
      out_of_range = ({2'b00, ADDR[31:2]} >= MEM_WORDS_W);
`ifdef LSU_MISALIGN_TRAP_EN
      misalign = f3_misaligned(FUNCT3, ADDR[1:0]);
`else
      misalign = 1'b0;
`endif
      fault_d = !f3_legal(WE, FUNCT3) || out_of_range || misalign;
   end

   // State register; reset wins over everything, including a new request
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: fault skips memory, sub-word stores read first
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (REQ) begin
               if (fault_d) begin
                  state_d = ST_RESP;
               end else if (WE && (FUNCT3 == F3_W)) begin
                  state_d = ST_WR;
               end else begin
                  state_d = ST_RD;
               end
            end
         end
         ST_RD:   state_d = we_q ? ST_WR : ST_RESP;
         ST_WR:   state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Request latches on acceptance, read word captured at the end of RD
   always_ff @(posedge CLK) begin
      if (RST) begin
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         err_q   <= 1'b0;
         word_q  <= 32'h0;
      end else begin
         if (accept) begin
            we_q    <= WE;
            f3_q    <= FUNCT3;
            addr_q  <= ADDR;
            wdata_q <= WDATA;
            err_q   <= fault_d;
         end
         if (state_q == ST_RD) begin
            word_q <= MEM_DOUT;
         end
      end
   end

   lsu_align u_align (
      .funct3_i (f3_q),
      .off_i    (addr_q[1:0]),
      .word_i   (word_q),
      .wdata_i  (wdata_q),
      .load_o   (load_word),
      .store_o  (store_word)
   );

   // Outputs decoded from state; RST forces every output low immediately
   always_comb begin
      MEM_EN    = 1'b0;
      MEM_RW    = 1'b0;
      MEM_ADDR  = 32'h0;
      MEM_DIN   = 32'h0;
      DONE      = 1'b0;
      BUSY      = 1'b0;
      ERR       = 1'b0;
      RDATA     = 32'h0;
      DBG_STATE = ST_IDLE;
      if (!RST) begin
         DBG_STATE = state_q;
         MEM_ADDR  = {addr_q[31:2], 2'b00};
         BUSY      = (state_q != ST_IDLE);
         case (state_q)
            ST_RD: begin
               MEM_EN = 1'b1;
            end
            ST_WR: begin
               MEM_EN  = 1'b1;
               MEM_RW  = 1'b1;
               MEM_DIN = store_word;
            end
            ST_RESP: begin
               DONE = 1'b1;
               ERR  = err_q;
               if (!we_q && !err_q) begin
                  RDATA = load_word;
               end
            end
            default: begin
               MEM_EN = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_core.sv
// Bench for lsu_core: directed vector table, reset/abort sequences and
// randomized accesses checked against an arithmetic reference model.
module tb_lsu_core;

   localparam int NW = 21;

   logic        CLK;
   logic        RST;
   logic        REQ;
   logic        WE;
   logic [2:0]  FUNCT3;
   logic [31:0] ADDR;
   logic [31:0] WDATA;
   logic [31:0] RDATA;
   logic        DONE;
   logic        BUSY;
   logic        ERR;
   logic        MEM_EN;
   logic        MEM_RW;
   logic [31:0] MEM_ADDR;
   logic [31:0] MEM_DIN;
   logic [31:0] MEM_DOUT;
   lsu_pkg::lsu_state_e dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   // Memory seen by the DUT, and the bench's expected memory image
   logic [31:0] mem [NW];
   logic [31:0] ref_mem [NW];
   logic        mem_clr;

   lsu_core #(.MEM_WORDS(NW)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .REQ       (REQ),
      .WE        (WE),
      .FUNCT3    (FUNCT3),
      .ADDR      (ADDR),
      .WDATA     (WDATA),
      .RDATA     (RDATA),
      .DONE      (DONE),
      .BUSY      (BUSY),
      .ERR       (ERR),
      .MEM_EN    (MEM_EN),
      .MEM_RW    (MEM_RW),
      .MEM_ADDR  (MEM_ADDR),
      .MEM_DIN   (MEM_DIN),
      .MEM_DOUT  (MEM_DOUT),
      .DBG_STATE (dbg_state)
   );

   // Clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   // Combinational-read, clocked-write word memory
   assign MEM_DOUT = (MEM_EN && !MEM_RW && (MEM_ADDR[31:2] < 30'd21)) ? mem[MEM_ADDR[6:2]] : 32'h0;

   always @(posedge CLK) begin
      if (mem_clr) begin
         for (int i = 0; i < NW; i++) mem[i] <= 32'h0;
      end else if (MEM_EN && MEM_RW && (MEM_ADDR[31:2] < 30'd21)) begin
         mem[MEM_ADDR[6:2]] <= MEM_DIN;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: result of one access computed from the width rules
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat, output logic [31:0] new_word);
      int unsigned idx, off, size;
      logic [31:0] mask, w, v;
      bit legal;
      idx   = addr >> 2;
      legal = we ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      size  = 1 << f3[1:0];
      err   = !legal || (idx >= NW);
`ifdef LSU_MISALIGN_TRAP_EN
      if (legal && (addr % size) != 0) err = 1'b1;
`endif
      rdata    = 32'h0;
      new_word = 32'h0;
      lat      = 1;
      if (!err) begin
         w = ref_mem[idx];
         if (size == 4) off = 0;
         else if (size == 2) off = ((addr % 4) / 2) * 2;
         else off = addr % 4;
         mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
         if (we) begin
            new_word = (w & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
            lat = (size == 4) ? 2 : 3;
         end else begin
            v = (w >> (8 * off)) & mask;
            if (!f3[2] && size != 4 && (v & ((mask >> 1) + 1)) != 0) v = v | ~mask;
            rdata = v;
            lat   = 2;
         end
      end
   endtask

   // Drive one access, follow it to DONE and check timing, data and memory
   task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_lat, input bit hold_req,
                          input string name);
      logic [31:0] m_rdata, m_new;
      logic m_err;
      int m_lat, n, mem_cycles, wr_cycles, idx;
      bit done_seen;
      model(we, f3, addr, wdata, m_rdata, m_err, m_lat, m_new);
      idx = int'(addr >> 2);
      @(negedge CLK);
      REQ = 1'b1; WE = we; FUNCT3 = f3; ADDR = addr; WDATA = wdata;
      @(posedge CLK);
      #1;
      REQ = hold_req; WE = 1'($urandom); FUNCT3 = 3'($urandom); ADDR = $urandom; WDATA = $urandom;
      n = 0; mem_cycles = 0; wr_cycles = 0; done_seen = 0;
      while (!done_seen && n < 8) begin
         @(negedge CLK);
         n++;
         check({name, ".busy"}, {31'h0, BUSY}, 32'h1);
         if (MEM_EN) begin
            mem_cycles++;
            check({name, ".mem_addr"}, MEM_ADDR, {addr[31:2], 2'b00});
            if (MEM_RW) begin
               wr_cycles++;
               check({name, ".mem_din"}, MEM_DIN, m_new);
            end
         end
         if (DONE) begin
            done_seen = 1;
            REQ = 1'b0;
         end else begin
            check({name, ".err_without_done"}, {31'h0, ERR}, 32'h0);
         end
      end
      REQ = 1'b0;
      if (!done_seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s.timeout: no DONE within %0d cycles, expected after %0d", name, n, exp_lat);
      end else begin
         check({name, ".latency"}, 32'(n), 32'(exp_lat));
         check({name, ".rdata"}, RDATA, exp_rdata);
         check({name, ".err"}, {31'h0, ERR}, {31'h0, exp_err});
         check({name, ".mem_cycles"}, 32'(mem_cycles), 32'(exp_lat - 1));
         check({name, ".wr_cycles"}, 32'(wr_cycles), (we && !exp_err) ? 32'h1 : 32'h0);
      end
      @(negedge CLK);
      check({name, ".idle_after"}, {30'h0, BUSY, DONE}, 32'h0);
      if (we && !m_err) ref_mem[idx] = m_new;
      if (idx < NW) check({name, ".mem_word"}, mem[idx], ref_mem[idx]);
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      string       name;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input logic exp_err, input int exp_lat, input string name);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat; v.name = name;
      return v;
   endfunction

   initial begin
      logic [31:0] r_rdata, r_new, r_addr, r_wdata;
      logic r_err, r_we;
      logic [2:0] r_f3;
      int r_lat;

      // Directed vectors: {we, funct3, addr, wdata, rdata, err, latency}
      vecs.push_back(mk(1, 3'b010, 32'h04, 32'h8899AABB, 32'h0, 0, 2, "sw_w1"));
      vecs.push_back(mk(0, 3'b000, 32'h05, 32'h0,        32'hFFFFFFAA, 0, 2, "lb_0x5"));
      vecs.push_back(mk(0, 3'b100, 32'h07, 32'h0,        32'h00000088, 0, 2, "lbu_0x7"));
      vecs.push_back(mk(0, 3'b001, 32'h06, 32'h0,        32'hFFFF8899, 0, 2, "lh_0x6"));
      vecs.push_back(mk(0, 3'b101, 32'h04, 32'h0,        32'h0000AABB, 0, 2, "lhu_0x4"));
      vecs.push_back(mk(1, 3'b010, 32'h08, 32'h11223344, 32'h0, 0, 2, "sw_w2"));
      vecs.push_back(mk(1, 3'b000, 32'h0A, 32'h000000EE, 32'h0, 0, 3, "sb_0xA"));
      vecs.push_back(mk(0, 3'b010, 32'h08, 32'h0,        32'h11EE3344, 0, 2, "lw_w2"));
      vecs.push_back(mk(1, 3'b010, 32'h00, 32'hCAFEF00D, 32'h0, 0, 2, "sw_0x0"));
      vecs.push_back(mk(0, 3'b010, 32'h00, 32'h0,        32'hCAFEF00D, 0, 2, "lw_0x0"));
      vecs.push_back(mk(0, 3'b010, 32'h54, 32'h0,        32'h0, 1, 1, "lw_oor_21"));
      vecs.push_back(mk(1, 3'b010, 32'h58, 32'h1,        32'h0, 1, 1, "sw_oor_22"));
      vecs.push_back(mk(0, 3'b011, 32'h00, 32'h0,        32'h0, 1, 1, "ld_illegal_011"));
      vecs.push_back(mk(1, 3'b100, 32'h00, 32'h5,        32'h0, 1, 1, "st_illegal_100"));
      vecs.push_back(mk(1, 3'b010, 32'h50, 32'h12345678, 32'h0, 0, 2, "sw_last"));
      vecs.push_back(mk(1, 3'b001, 32'h52, 32'h0000BEEF, 32'h0, 0, 3, "sh_last_hi"));
      vecs.push_back(mk(0, 3'b010, 32'h50, 32'h0,        32'hBEEF5678, 0, 2, "lw_last"));
      vecs.push_back(mk(0, 3'b000, 32'h51, 32'h0,        32'h00000056, 0, 2, "lb_last_1"));
      vecs.push_back(mk(1, 3'b010, 32'h00, 32'h7FFF0001, 32'h0, 0, 2, "sw_w0"));
`ifdef LSU_MISALIGN_TRAP_EN
      vecs.push_back(mk(0, 3'b001, 32'h03, 32'h0,        32'h0, 1, 1, "lh_0x3"));
      vecs.push_back(mk(0, 3'b010, 32'h02, 32'h0,        32'h0, 1, 1, "lw_0x2"));
      vecs.push_back(mk(1, 3'b001, 32'h01, 32'h0,        32'h0, 1, 1, "sh_0x1"));
`else
      vecs.push_back(mk(0, 3'b001, 32'h03, 32'h0,        32'h00007FFF, 0, 2, "lh_0x3"));
      vecs.push_back(mk(0, 3'b010, 32'h02, 32'h0,        32'h7FFF0001, 0, 2, "lw_0x2"));
      vecs.push_back(mk(1, 3'b001, 32'h01, 32'h0000ABCD, 32'h0, 0, 3, "sh_0x1"));
      vecs.push_back(mk(0, 3'b010, 32'h00, 32'h0,        32'h7FFFABCD, 0, 2, "lw_after_sh"));
`endif

      for (int i = 0; i < NW; i++) ref_mem[i] = 32'h0;

      // Reset with a coincident request: outputs low, request dropped
      RST = 1'b1; mem_clr = 1'b1; REQ = 1'b1; WE = 1'b0; FUNCT3 = 3'b010;
      ADDR = 32'h4; WDATA = 32'h0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst.rdata", RDATA, 32'h0);
      check("rst.flags", {28'h0, DONE, BUSY, ERR, MEM_EN}, 32'h0);
      check("rst.mem_rw", {31'h0, MEM_RW}, 32'h0);
      check("rst.mem_addr", MEM_ADDR, 32'h0);
      check("rst.mem_din", MEM_DIN, 32'h0);
      check("rst.state", 32'(dbg_state), 32'h0);
      @(posedge CLK);
      #1;
      RST = 1'b0; mem_clr = 1'b0; REQ = 1'b0;
      @(negedge CLK);
      check("rst.req_dropped", {30'h0, BUSY, DONE}, 32'h0);

      // Directed table
      for (int i = 0; i < vecs.size(); i++) begin
         run_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
                 vecs[i].exp_err, vecs[i].exp_lat, (i % 2) == 1, vecs[i].name);
      end

      // Reset during the write half of a halfword store aborts the write
      run_txn(1, 3'b010, 32'h0C, 32'h55667788, 32'h0, 0, 2, 0, "sw_w3");
      @(negedge CLK);
      REQ = 1'b1; WE = 1'b1; FUNCT3 = 3'b001; ADDR = 32'h0E; WDATA = 32'h0000ABCD;
      @(posedge CLK);
      #1;
      @(negedge CLK);
      check("abort.rd_cycle", {29'h0, BUSY, MEM_EN, MEM_RW}, 32'h6);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      @(negedge CLK);
      check("abort.wr_suppressed", {28'h0, MEM_EN, MEM_RW, BUSY, DONE}, 32'h0);
      check("abort.mem_din", MEM_DIN, 32'h0);
      @(posedge CLK);
      #1;
      RST = 1'b0; REQ = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         check("abort.no_done", {30'h0, BUSY, DONE}, 32'h0);
      end
      check("abort.mem_unchanged", mem[3], 32'h55667788);

      // Randomized accesses against the reference model
      for (int t = 0; t < 200; t++) begin
         r_we    = 1'($urandom);
         r_f3    = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7));
         r_addr  = {$urandom_range(0, 22), 2'($urandom)};
         r_wdata = $urandom;
         model(r_we, r_f3, r_addr, r_wdata, r_rdata, r_err, r_lat, r_new);
         run_txn(r_we, r_f3, r_addr, r_wdata, r_rdata, r_err, r_lat, 1'($urandom), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
